// File: rtl/median_window_scheduler.sv
// Front-end sequencer for the median chain: per window it pushes one control-token
// set, then forwards that window's pixels, bounding windows in flight with credits.
module median_window_scheduler #(
  parameter int BUFF_SIZE     = 16,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int MEDIAN_POS    = 8,
  parameter int DEFAULT_PIVOT = 127,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [BUFF_SIZE_BIT-1:0]         cfg_buff_size,
  input  logic [BUFF_SIZE_BIT-1:0]         cfg_median_pos,
  input  logic [7:0]                       src_px,
  input  logic                             src_px_empty,
  output logic                             src_px_rd,
  output logic [7:0]                       out_px,
  output logic                             out_px_wr,
  input  logic                             out_px_full,
  output logic [7:0]                       out_pivot,
  output logic [BUFF_SIZE_BIT-1:0]         out_buff_size,
  output logic [BUFF_SIZE_BIT-1:0]         out_median_pos,
  output logic [7:0]                       out_second_median_value,
  output logic                             out_pivot_wr,
  output logic                             out_buff_size_wr,
  output logic                             out_median_pos_wr,
  output logic                             out_second_median_value_wr,
  input  logic                             out_pivot_full,
  input  logic                             out_buff_size_full,
  input  logic                             out_median_pos_full,
  input  logic                             out_second_median_value_full,
  input  logic [7:0]                       res_median,
  input  logic                             res_empty,
  output logic                             res_rd,
  output logic [7:0]                       median_out,
  output logic                             median_valid,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                             busy
);

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
  localparam logic [BUFF_SIZE_BIT-1:0] POS_DEF  = BUFF_SIZE_BIT'(MEDIAN_POS);
  localparam logic [INF_W-1:0]         INF_MAX  = INF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, WAIT, CTRL, PIX} state_t;

  state_t                   state, state_next;
  logic [BUFF_SIZE_BIT-1:0] win_size, win_pos, pix_cnt;
  logic [BUFF_SIZE_BIT-1:0] size_res, pos_res;
  logic [3:0]               done, tok_wr, tok_full;
  logic                     px_xfer, last_px, credit_ok, pop;

  // Token bit order throughout: 0 pivot, 1 buff_size, 2 median_pos, 3 second value.
  assign tok_full = {out_second_median_value_full, out_median_pos_full,
                     out_buff_size_full, out_pivot_full};

  always_comb begin
    size_res  = cfg_buff_size;
    pos_res   = cfg_median_pos;
    if (cfg_buff_size == '0 || cfg_buff_size > SIZE_MAX) size_res = SIZE_MAX;
    if (cfg_median_pos == '0) pos_res = POS_DEF;
    tok_wr    = (state == CTRL) ? (~done & ~tok_full) : 4'b0000;
    px_xfer   = (state == PIX) && !src_px_empty && !out_px_full;
    last_px   = px_xfer && (pix_cnt == win_size - 1'b1);
    credit_ok = inflight < INF_MAX;
    pop       = !res_empty && (inflight != '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = WAIT;
      WAIT: if (credit_ok) state_next = CTRL;
      CTRL: if (&(done | tok_wr)) state_next = PIX;
      PIX:  if (last_px) state_next = enable ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      win_size     <= SIZE_MAX;
      win_pos      <= POS_DEF;
      done         <= 4'b0000;
      pix_cnt      <= '0;
      inflight     <= '0;
      median_out   <= 8'h00;
      median_valid <= 1'b0;
    end else begin
      state        <= state_next;
      median_valid <= pop;
      if (pop) median_out <= res_median;
      // A completion and a pop in the same cycle cancel out.
      case ({last_px, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (state == WAIT && credit_ok) begin
        win_size <= size_res;
        win_pos  <= pos_res;
        done     <= 4'b0000;
      end else if (state == CTRL) begin
        done <= done | tok_wr;
      end
      if (state == CTRL) pix_cnt <= '0;
      else if (px_xfer)  pix_cnt <= pix_cnt + 1'b1;
    end
  end

  assign out_pivot                  = 8'(DEFAULT_PIVOT);
  assign out_second_median_value    = 8'(DEFAULT_PIVOT);
  assign out_buff_size              = win_size;
  assign out_median_pos             = win_pos;
  assign out_pivot_wr               = tok_wr[0];
  assign out_buff_size_wr           = tok_wr[1];
  assign out_median_pos_wr          = tok_wr[2];
  assign out_second_median_value_wr = tok_wr[3];
  assign out_px                     = src_px;
  assign out_px_wr                  = px_xfer;
  assign src_px_rd                  = px_xfer;
  assign res_rd                     = pop;
  assign busy                       = (state != IDLE);

endmodule

// File: tb/tb_median_window_scheduler.sv
// Bench for median_window_scheduler: a window-level scoreboard checks every cycle,
// driven by a config table, hand-written corner sequences and random traffic.
module tb_median_window_scheduler;

  localparam int BUFF_SIZE     = 16;
  localparam int BSB           = 5;
  localparam int MEDIAN_POS    = 8;
  localparam int DEFAULT_PIVOT = 127;
  localparam int MAX_INFLIGHT  = 4;

  logic           clock = 1'b0;
  logic           reset, enable;
  logic [BSB-1:0] cfg_buff_size, cfg_median_pos;
  logic [7:0]     src_px;
  logic           src_px_empty, src_px_rd;
  logic [7:0]     out_px;
  logic           out_px_wr, out_px_full;
  logic [7:0]     out_pivot, out_second_median_value;
  logic [BSB-1:0] out_buff_size, out_median_pos;
  logic           out_pivot_wr, out_buff_size_wr, out_median_pos_wr, out_second_median_value_wr;
  logic           out_pivot_full, out_buff_size_full, out_median_pos_full, out_second_median_value_full;
  logic [7:0]     res_median;
  logic           res_empty, res_rd;
  logic [7:0]     median_out;
  logic           median_valid;
  logic [2:0]     inflight;
  logic           busy;

  median_window_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_buff_size(cfg_buff_size), .cfg_median_pos(cfg_median_pos),
    .src_px(src_px), .src_px_empty(src_px_empty), .src_px_rd(src_px_rd),
    .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
    .out_pivot(out_pivot), .out_buff_size(out_buff_size),
    .out_median_pos(out_median_pos), .out_second_median_value(out_second_median_value),
    .out_pivot_wr(out_pivot_wr), .out_buff_size_wr(out_buff_size_wr),
    .out_median_pos_wr(out_median_pos_wr), .out_second_median_value_wr(out_second_median_value_wr),
    .out_pivot_full(out_pivot_full), .out_buff_size_full(out_buff_size_full),
    .out_median_pos_full(out_median_pos_full), .out_second_median_value_full(out_second_median_value_full),
    .res_median(res_median), .res_empty(res_empty), .res_rd(res_rd),
    .median_out(median_out), .median_valid(median_valid),
    .inflight(inflight), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cfg_size;
    int cfg_pos;
    int exp_size;
    int exp_pos;
  } vec_t;

  vec_t       vecs[6];
  int         total = 0, bad = 0;
  logic [7:0] src_q[$];
  logic [7:0] res_q[$];
  bit         stall_src, hold_res;
  // Window-level model of what the chain should have received so far.
  int         model_inflight, px_seen, exp_size, exp_pos, completed, windows_started;
  logic [3:0] tok_seen;
  bit         exp_valid;
  logic [7:0] exp_median;
  logic [3:0] cyc_tok_wr;
  bit         cyc_px, cyc_rd, cyc_done, cyc_pop;
  string      tok_name[4] = '{"tok_pivot", "tok_buff_size", "tok_median_pos", "tok_second"};
  int         first_tok_t, done_t, rand_done;
  logic [3:0] first_tok_wr;

  function automatic int resolveSize(input int c);
    return (c == 0 || c > BUFF_SIZE) ? BUFF_SIZE : c;
  endfunction

  function automatic int resolvePos(input int c);
    return (c == 0) ? MEDIAN_POS : c;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    model_inflight = 0; px_seen = 0; tok_seen = 4'b0000; exp_valid = 1'b0;
    completed = 0; windows_started = 0;
    cyc_tok_wr = 4'b0000; cyc_px = 0; cyc_rd = 0; cyc_done = 0; cyc_pop = 0;
  endtask

  task automatic monitor();
    logic [3:0] wr, full, prev_seen;
    int         tok_val[4], tok_exp[4];
    bit         done_now, pop_now;
    wr   = {out_second_median_value_wr, out_median_pos_wr, out_buff_size_wr, out_pivot_wr};
    full = {out_second_median_value_full, out_median_pos_full, out_buff_size_full, out_pivot_full};
    tok_val = '{int'(out_pivot), int'(out_buff_size), int'(out_median_pos), int'(out_second_median_value)};
    tok_exp = '{DEFAULT_PIVOT, exp_size, exp_pos, DEFAULT_PIVOT};
    checkOutput("inflight", inflight, model_inflight);
    checkOutput("median_valid", median_valid, exp_valid);
    if (exp_valid) checkOutput("median_out", median_out, exp_median);
    checkOutput("res_rd", res_rd, (!res_empty && model_inflight != 0));
    if (src_px_rd || out_px_wr) checkOutput("rd_eq_wr", src_px_rd, out_px_wr);
    prev_seen = tok_seen;
    if (wr != 4'b0000) begin
      if (prev_seen == 4'b0000) begin
        checkOutput("credit", (model_inflight < MAX_INFLIGHT), 1);
        windows_started++;
      end
      checkOutput("tok_after_px", px_seen, 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (wr[i]) begin
        checkOutput("tok_full", full[i], 0);
        checkOutput("tok_dup", prev_seen[i], 0);
        checkOutput(tok_name[i], tok_val[i], tok_exp[i]);
        tok_seen[i] = 1'b1;
      end
    end
    if (prev_seen == 4'hF && !src_px_empty && !out_px_full) checkOutput("px_move", out_px_wr, 1);
    done_now = 0;
    if (out_px_wr) begin
      checkOutput("px_tokens", prev_seen, 4'hF);
      checkOutput("px_full", out_px_full, 0);
      checkOutput("px_empty", src_px_empty, 0);
      if (src_q.size() > 0) begin
        checkOutput("px_value", out_px, src_q[0]);
        void'(src_q.pop_front());
      end
      px_seen++;
      if (px_seen >= exp_size) begin
        done_now = 1; px_seen = 0; tok_seen = 4'b0000; completed++;
      end
    end
    pop_now = res_rd;
    if (pop_now && res_q.size() > 0) exp_median = res_q.pop_front();
    model_inflight = model_inflight + (done_now ? 1 : 0) - (pop_now ? 1 : 0);
    exp_valid  = pop_now;
    cyc_tok_wr = wr; cyc_px = out_px_wr; cyc_rd = src_px_rd; cyc_done = done_now; cyc_pop = pop_now;
  endtask

  // One clock cycle: drive from the FIFO models, sample mid-cycle, advance.
  task automatic tick();
    src_px_empty = (src_q.size() == 0) || stall_src;
    src_px       = (src_q.size() != 0) ? src_q[0] : 8'h00;
    res_empty    = (res_q.size() == 0) || hold_res;
    res_median   = (res_q.size() != 0) ? res_q[0] : 8'h00;
    #2;
    if (reset) clearModel();
    else monitor();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic setFull(input bit v);
    out_pivot_full = v; out_buff_size_full = v; out_median_pos_full = v;
    out_second_median_value_full = v; out_px_full = v;
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b0; setFull(1'b0);
    stall_src = 0; hold_res = 0; src_q.delete(); res_q.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic checkResetValues();
    src_px_empty = 1'b0; res_empty = 1'b0; setFull(1'b0);
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_median_out", median_out, 0);
    checkOutput("rst_median_valid", median_valid, 0);
    checkOutput("rst_strobes", {out_pivot_wr, out_buff_size_wr, out_median_pos_wr,
                out_second_median_value_wr, out_px_wr, src_px_rd, res_rd}, 0);
    checkOutput("rst_pivot", out_pivot, DEFAULT_PIVOT);
    checkOutput("rst_second", out_second_median_value, DEFAULT_PIVOT);
    checkOutput("rst_buff_size", out_buff_size, BUFF_SIZE);
    checkOutput("rst_median_pos", out_median_pos, MEDIAN_POS);
  endtask

  task automatic startWindow(input int cs, input int cp, input int npx, input int base);
    doReset();
    cfg_buff_size  = BSB'(cs);
    cfg_median_pos = BSB'(cp);
    exp_size = resolveSize(cs);
    exp_pos  = resolvePos(cp);
    for (int i = 0; i < npx; i++) src_q.push_back(8'(base + i));
    enable = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    startWindow(v.cfg_size, v.cfg_pos, v.exp_size, v.cfg_size * 3);
    exp_size = v.exp_size;
    exp_pos  = v.exp_pos;
    first_tok_t = -1; first_tok_wr = 4'b0000; done_t = -1;
    for (int t = 0; t < 60 && done_t < 0; t++) begin
      tick();
      if (cyc_tok_wr != 4'b0000 && first_tok_t < 0) begin
        first_tok_t = t; first_tok_wr = cyc_tok_wr;
      end
      if (cyc_done) done_t = t;
    end
  endtask

  initial begin
    int t0, pos_t, px_t, stall_left, stall_rd;
    bit stalled, sim_hit;
    reset = 1'b1; enable = 1'b0; cfg_buff_size = '0; cfg_median_pos = '0;
    src_px = 8'h00; src_px_empty = 1'b1; res_median = 8'h00; res_empty = 1'b1;
    setFull(1'b0); stall_src = 0; hold_res = 0; exp_size = BUFF_SIZE; exp_pos = MEDIAN_POS;
    rand_done = 0;
    vecs[0] = '{0, 0, 16, 8};
    vecs[1] = '{9, 4, 9, 4};
    vecs[2] = '{20, 3, 16, 3};
    vecs[3] = '{16, 16, 16, 16};
    vecs[4] = '{1, 0, 1, 8};
    vecs[5] = '{17, 31, 16, 31};

    $display("[TB] reset values");
    res_q.push_back(8'h55);
    doReset();
    checkResetValues();

    $display("[TB] config table");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput("first_tok_cycle", first_tok_t, 2);
      checkOutput("first_tok_set", first_tok_wr, 4'hF);
      checkOutput("window_done_cycle", done_t, 2 + vecs[k].exp_size);
      checkOutput("inflight_after", inflight, 1);
      checkOutput("busy_after", busy, 1);
    end

    $display("[TB] token and pixel backpressure");
    startWindow(0, 0, 16, 100);
    out_median_pos_full = 1'b1;
    t0 = -1; pos_t = -1; px_t = -1; done_t = -1; stall_left = 0; stall_rd = 0; stalled = 0;
    first_tok_wr = 4'b0000;
    for (int t = 0; t < 60 && completed == 0; t++) begin
      if (t0 >= 0 && t - t0 >= 3) out_median_pos_full = 1'b0;
      if (!stalled && px_seen == 5) begin
        out_px_full = 1'b1; stalled = 1; stall_left = 3;
      end
      tick();
      if (stall_left > 0) begin
        stall_rd += cyc_rd;
        stall_left--;
        if (stall_left == 0) out_px_full = 1'b0;
      end
      if (cyc_tok_wr != 4'b0000 && t0 < 0) begin t0 = t; first_tok_wr = cyc_tok_wr; end
      if (cyc_tok_wr[2]) pos_t = t;
      if (cyc_px && px_t < 0) px_t = t;
      if (cyc_done) done_t = t;
    end
    checkOutput("bp_first_tokens", first_tok_wr, 4'b1011);
    checkOutput("bp_pos_delay", pos_t - t0, 3);
    checkOutput("bp_pix_start", px_t, pos_t + 1);
    checkOutput("bp_stall_rd", stall_rd, 0);
    checkOutput("bp_done_cycle", done_t, px_t + 18);

    $display("[TB] credit limit");
    startWindow(2, 0, 40, 7);
    repeat (60) tick();
    checkOutput("credit_windows", windows_started, 4);
    checkOutput("credit_done", completed, 4);
    checkOutput("credit_inflight", inflight, 4);
    checkOutput("credit_busy", busy, 1);
    res_q.push_back(8'd42);
    tick();
    checkOutput("credit_pop", cyc_pop, 1);
    #1;
    checkOutput("pop_valid", median_valid, 1);
    checkOutput("pop_value", median_out, 42);
    checkOutput("pop_inflight", inflight, 3);
    for (int t = 0; t < 20 && windows_started < 5; t++) tick();
    checkOutput("fifth_window", windows_started, 5);

    $display("[TB] completion and pop together");
    startWindow(3, 0, 20, 60);
    for (int t = 0; t < 40 && completed < 1; t++) tick();
    sim_hit = 0;
    for (int t = 0; t < 40 && completed < 2; t++) begin
      if (!sim_hit && tok_seen == 4'hF && px_seen == exp_size - 1 && res_q.size() == 0)
        res_q.push_back(8'h99);
      tick();
      if (cyc_pop) begin
        sim_hit = 1;
        checkOutput("sim_done_with_pop", cyc_done, 1);
        #1;
        checkOutput("sim_inflight", inflight, 1);
      end
    end
    checkOutput("sim_pop_seen", sim_hit, 1);

    $display("[TB] enable low mid-window");
    startWindow(6, 0, 20, 30);
    for (int t = 0; t < 40 && px_seen != 2; t++) tick();
    enable = 1'b0;
    for (int t = 0; t < 40 && completed < 1; t++) tick();
    checkOutput("en_low_done", completed, 1);
    #1;
    checkOutput("en_low_busy", busy, 0);
    repeat (5) tick();
    checkOutput("en_low_no_new", windows_started, 1);

    $display("[TB] reset mid-window");
    startWindow(2, 0, 20, 200);
    for (int t = 0; t < 40 && completed < 1; t++) tick();
    res_q.push_back(8'hA5);
    for (int t = 0; t < 40 && !(tok_seen == 4'hF && px_seen == 1); t++) tick();
    checkOutput("pre_reset_median", median_out, 8'hA5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetValues();

    $display("[TB] random traffic");
    for (int ph = 0; ph < 3; ph++) begin
      startWindow(int'($urandom_range(0, 20)), int'($urandom_range(0, 31)), 0, 0);
      for (int t = 0; t < 700; t++) begin
        enable                       = ($urandom_range(0, 9) != 0);
        out_pivot_full               = ($urandom_range(0, 3) == 0);
        out_buff_size_full           = ($urandom_range(0, 3) == 0);
        out_median_pos_full          = ($urandom_range(0, 3) == 0);
        out_second_median_value_full = ($urandom_range(0, 3) == 0);
        out_px_full                  = ($urandom_range(0, 4) == 0);
        stall_src                    = ($urandom_range(0, 4) == 0);
        hold_res                     = ($urandom_range(0, 2) == 0);
        if (src_q.size() < 4) src_q.push_back(8'($urandom));
        if (res_q.size() < 3 && $urandom_range(0, 3) == 0) res_q.push_back(8'($urandom));
        tick();
      end
      rand_done += completed;
    end
    checkOutput("random_progress", (rand_done > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_window_scheduler.md
# median_window_scheduler

Front-end sequencer for the median filter's middle-actor chain. It slices an incoming pixel stream into windows of a configurable size. For each window it first emits one control-token set (pivot, buff_size, median_pos, second_median_value) into the chain's control FIFOs, then forwards exactly that window's pixels. It bounds the number of windows in flight with a credit counter that is replenished by the median results returning from the tail of the chain.

## Interface
Parameters:
- BUFF_SIZE, 16: maximum window length.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1: width of size/position fields.
- MEDIAN_POS, 8: default median position.
- DEFAULT_PIVOT, 127: initial pivot and second_median_value token.
- MAX_INFLIGHT, 4: maximum windows issued but not yet resolved (range 1..15).

Ports (clock and reset first):
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  level; high = issue windows.
- cfg_buff_size  in  BUFF_SIZE_BIT  window length; 0 or >BUFF_SIZE means BUFF_SIZE.
- cfg_median_pos  in  BUFF_SIZE_BIT  median position; 0 means MEDIAN_POS.
- src_px  in  8  source pixel.
- src_px_empty  in  1  source FIFO empty.
- src_px_rd  out  1  source pop.
- out_px  out  8  pixel to chain, equal to src_px.
- out_px_wr  out  1  push into the chain's px FIFO.
- out_px_full  in  1  chain px FIFO full.
- out_pivot / out_buff_size / out_median_pos / out_second_median_value  out  8 / BSB / BSB / 8  control tokens.
- out_pivot_wr / out_buff_size_wr / out_median_pos_wr / out_second_median_value_wr  out  1  token pushes.
- out_pivot_full / out_buff_size_full / out_median_pos_full / out_second_median_value_full  in  1  token FIFO full flags.
- res_median  in  8  resolved median from chain tail.
- res_empty  in  1  result FIFO empty.
- res_rd  out  1  result pop.
- median_out  out  8  registered last median.
- median_valid  out  1  one-cycle pulse per consumed result.
- inflight  out  $clog2(MAX_INFLIGHT+1)  windows outstanding.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, WAIT, CTRL, PIX.
- IDLE: if enable=1, go to WAIT.
- WAIT: if inflight < MAX_INFLIGHT, go to CTRL and latch the window config:
  - win_size = resolved cfg_buff_size.
  - win_pos = resolved cfg_median_pos.
  - Clear the four token-done flags.
- CTRL: each token is pushed independently.
  - Token x is written when its done flag is 0 and its full input is 0. A write sets the done flag.
  - Token values: pivot=DEFAULT_PIVOT, buff_size=win_size, median_pos=win_pos, second_median_value=DEFAULT_PIVOT.
  - Each token is written exactly once per window, never twice.
  - When all four flags are set (counting writes made this cycle), go to PIX with pix_cnt=0.
- PIX: pass-through.
  - src_px_rd = out_px_wr = ~src_px_empty & ~out_px_full.
  - out_px = src_px, combinational.
  - pix_cnt increments on each transfer.
  - On the transfer where pix_cnt == win_size-1:
    - inflight increments.
    - If enable=1, go to WAIT; else go to IDLE.
- enable dropping mid-window does not abort; the window completes.
- Result side, independent of state (IDLE included):
  - res_rd = ~res_empty & (inflight != 0).
  - On a pop: median_out <= res_median, median_valid=1 the next cycle, inflight decrements.
- Simultaneous window completion and result pop: inflight unchanged.
- inflight never wraps:
  - A pop at inflight=0 is blocked.
  - Issue is blocked at MAX_INFLIGHT.
- All *_wr outputs are 0 outside their state. No write is ever asserted while the matching full input is 1.

## Timing
- Reset values:
  - State IDLE; busy=0; inflight=0.
  - median_out=0; median_valid=0.
  - All *_wr=0; src_px_rd=0; res_rd=0.
  - out_pivot and out_second_median_value = DEFAULT_PIVOT.
  - out_buff_size=BUFF_SIZE; out_median_pos=MEDIAN_POS.
- Reset mid-window: counters and flags clear next edge; any partial window is abandoned (the chain is reset alongside).
- Latency:
  - enable to first token write: 2 cycles (IDLE→WAIT→CTRL).
  - CTRL lasts 1 cycle when no token FIFO is full.
  - PIX transfers 1 pixel/cycle; throughput is win_size+2 cycles per window back-to-back.
  - Result pop to median_valid: 1 cycle.
- Token/pixel outputs are combinational from state and registered config; all write strobes are also gated combinationally by full/empty.

## Test plan
- Basic: cfg_buff_size=0, cfg_median_pos=0, enable=1, 16 pixels 0..15 available, no full.
  - One write each: pivot=127, buff_size=16, median_pos=8, second=127.
  - Then 16 out_px_wr, one per cycle.
  - inflight=1; state WAIT.
- Backpressure: out_median_pos_full held for 3 CTRL cycles.
  - Other three tokens are written once in the first cycle; median_pos is written on cycle 4; PIX entered after.
  - Stall out_px_full mid-window: no src_px_rd and no pixel loss.
- Credit limit: MAX_INFLIGHT=4, no results.
  - Exactly 4 windows issued; stays in WAIT.
  - One res_median=42 pop → median_valid pulse with median_out=42, inflight=3, fifth window issued.
- Simultaneous: result pop on the last-pixel cycle of a window → inflight unchanged.
- Config resolve: cfg_buff_size=9, cfg_median_pos=4.
  - Tokens carry 9 and 4; exactly 9 pixels forwarded.
  - cfg_buff_size=20 → 16 used.
- Enable low / reset mid-PIX:
  - enable low → window finishes, then IDLE with busy=0.
  - reset mid-PIX → all outputs at reset values next cycle.
